imm_decode_stage: RTL
=====================

# imm_decode_stage

Registered, parametrised immediate-generation stage for the RV32I/RV64I decode pipeline. It decodes the instruction format from the opcode, sign-extends the immediate to XLEN, and flags unsupported opcodes. Results pass through a two-entry skid buffer with valid/ready handshakes on both sides. It sits between the fetch/IF-ID register and the register-read/execute stage, and adds full-throughput buffering and flush support.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 32: width of the sideband tag (normally the PC), carried unmodified alongside the instruction.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all held entries.
- in_valid  in  1  an instruction is presented on the input.
- in_ready  out  1  the stage can accept an instruction this cycle.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  a result is presented on the output.
- out_ready  in  1  downstream accepts the output this cycle.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5=R (no immediate).
- out_illegal  out  1  the opcode is not supported.
- out_tag  out  TAG_W  tag of the output entry.

## Operation
- **Opcode to format mapping** (opcode is in_instr[6:0]):
  - U: 0110111 (LUI), 0010111 (AUIPC).
  - J: 1101111 (JAL).
  - I: 1100111 (JALR), 0000011 (LOAD), 0010011 (OP-IMM), 0001111 (FENCE), 1110011 (SYSTEM).
  - B: 1100011.
  - S: 0100011.
  - R: 0110011.
  - XLEN=64 only: 0011011 (OP-IMM-32) is I; 0111011 (OP-32) is R.
  - Any other opcode: out_illegal=1, out_fmt=5, out_imm=0.
- **Immediate construction** (s = instr[31], replicated up to XLEN):
  - I: {s…, instr[31:20]}.
  - S: {s…, instr[31:25], instr[11:7]}.
  - B: {s…, instr[7], instr[30:25], instr[11:8], 0}, where instr[31] fills bit 12 and above.
  - U: {s…, instr[31:12], 12'b0}. For XLEN=64, bits 63:32 are copies of instr[31].
  - J: {s…, instr[19:12], instr[20], instr[30:21], 0}.
  - R: 0.
- Decode is combinational on the input side; the result is captured into the buffer on acceptance.
- **Buffer**: two entries, main (M) and skid (K), each holding {imm, fmt, illegal, tag} plus a valid bit. The output always presents M.
- **Handshakes**:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready is the registered value of !K.valid.
- **Per-cycle update, with input transfer i and output transfer o**:
  - M empty, i: write M.
  - M full, o, K empty: M ← input if i, otherwise M becomes empty.
  - M full, o, K full: M ← K, and K becomes empty. No input is accepted in this case, because in_ready=0.
  - M full, !o, i: write K.
- Order is preserved strictly. No entry is dropped or duplicated.
- **Flush**: both valid bits clear on the next edge. Flush takes priority over a same-cycle input transfer, which is discarded. An output transfer in the flush cycle still completes.
- **Reset**: while rst_n=0, transfers are ignored.

## Timing
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, and both valid bits 0.
- Latency: an instruction accepted at edge N appears with out_valid=1 in the cycle after edge N.
- Throughput: one instruction per cycle while out_ready=1.
- Stalls:
  - After out_ready falls, one further input is absorbed into K.
  - in_ready falls the cycle after K fills.
  - in_ready rises the cycle after K drains.
- out_* and in_ready are driven only from registers; there is no combinational path from in_* or out_ready to any output.
- Reset asserted mid-stream empties the stage immediately, without waiting for an edge.
- Flush empties the stage at the next edge: out_valid=0 in the following cycle and in_ready=1.

## Test plan
- **I and S formats, XLEN=32**:
  - 0xFFF00093 (addi -1) → out_imm=0xFFFFFFFF, fmt=0, one cycle after acceptance.
  - 0xFE20AE23 (sw -4) → out_imm=0xFFFFFFFC, fmt=1.
- **B and J formats**:
  - 0xFE000CE3 (beq -8) → out_imm=0xFFFFFFF8, fmt=2.
  - 0x0010006F (jal +2048) → out_imm=0x00000800, fmt=4.
- **U format at both widths**: 0x800002B7 (lui 0x80000) → out_imm=0x80000000 at XLEN=32, and 0xFFFFFFFF80000000 at XLEN=64, with fmt=3.
- **Illegal opcodes**:
  - 0x00000000 → out_illegal=1, out_imm=0, fmt=5.
  - 0x0000001B (OP-IMM-32) is illegal at XLEN=32 and I-format at XLEN=64.
- **Backpressure**:
  - Stimulus: stream tags 1..5 with in_valid=1; hold out_ready=0 for 3 cycles after the first output appears.
  - Required response: in_ready=0 after tags 1–2 are held, then tags 1..5 are delivered in order with no loss or duplicates.
- **Flush and reset**:
  - Flush with both entries full, plus a simultaneous input → out_valid=0 next cycle and the simultaneous input is discarded.
  - rst_n pulsed low mid-stream → outputs return to reset values immediately.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Immediate-generation decode stage: opcode -> format, sign-extended immediate,
// illegal flag, delivered through a two-entry skid buffer with valid/ready on both sides.
module imm_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_I = 3'd0;
  localparam logic [FMT_W-1:0] FMT_S = 3'd1;
  localparam logic [FMT_W-1:0] FMT_B = 3'd2;
  localparam logic [FMT_W-1:0] FMT_U = 3'd3;
  localparam logic [FMT_W-1:0] FMT_J = 3'd4;
  localparam logic [FMT_W-1:0] FMT_R = 3'd5;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_FENCE    = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [6:0]       w_opcode;
  logic [FMT_W-1:0] w_fmt;
  logic             w_illegal;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  entry_t           w_in_entry;

  entry_t r_m;
  entry_t r_k;
  logic   r_m_valid;
  logic   r_k_valid;
  logic   r_in_ready;

  entry_t w_m_nxt;
  entry_t w_k_nxt;
  logic   w_m_valid_nxt;
  logic   w_k_valid_nxt;
  logic   w_in_xfer;
  logic   w_out_xfer;

  assign w_opcode = in_instr[6:0];

  // Opcode to format; RV64-only opcodes are illegal on a 32-bit datapath
  always_comb begin
    w_fmt     = FMT_R;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC:                                   w_fmt = FMT_U;
      OP_JAL:                                             w_fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE, OP_SYSTEM:    w_fmt = FMT_I;
      OP_BRANCH:                                          w_fmt = FMT_B;
      OP_STORE:                                           w_fmt = FMT_S;
      OP_OP:                                              w_fmt = FMT_R;
      OP_OPIMM32: begin
        if (XLEN == 64) w_fmt = FMT_I;
        else            w_illegal = 1'b1;
      end
      OP_OP32: begin
        if (XLEN != 64) w_illegal = 1'b1;
      end
      default:                                            w_illegal = 1'b1;
    endcase
  end

  // 32-bit immediate per format; R and illegal produce zero
  always_comb begin
    w_imm32 = 32'd0;
    if (!w_illegal) begin
      case (w_fmt)
        FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        FMT_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
        FMT_U:   w_imm32 = {in_instr[31:12], 12'd0};
        FMT_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
        default: w_imm32 = 32'd0;
      endcase
    end
  end

  assign w_imm = XLEN'($signed(w_imm32));

  assign w_in_entry.imm     = w_imm;
  assign w_in_entry.fmt     = w_fmt;
  assign w_in_entry.illegal = w_illegal;
  assign w_in_entry.tag     = in_tag;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_m_valid && out_ready;

  // Skid-buffer next state: main entry always feeds the output, skid absorbs one stall
  always_comb begin
    w_m_nxt       = r_m;
    w_k_nxt       = r_k;
    w_m_valid_nxt = r_m_valid;
    w_k_valid_nxt = r_k_valid;
    if (flush) begin
      w_m_valid_nxt = 1'b0;
      w_k_valid_nxt = 1'b0;
    end else if (!r_m_valid) begin
      if (w_in_xfer) begin
        w_m_nxt       = w_in_entry;
        w_m_valid_nxt = 1'b1;
      end
    end else if (w_out_xfer) begin
      if (r_k_valid) begin
        w_m_nxt       = r_k;
        w_k_valid_nxt = 1'b0;
      end else if (w_in_xfer) begin
        w_m_nxt       = w_in_entry;
      end else begin
        w_m_valid_nxt = 1'b0;
      end
    end else if (w_in_xfer) begin
      w_k_nxt       = w_in_entry;
      w_k_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m        <= '0;
      r_k        <= '0;
      r_m_valid  <= 1'b0;
      r_k_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_m        <= w_m_nxt;
      r_k        <= w_k_nxt;
      r_m_valid  <= w_m_valid_nxt;
      r_k_valid  <= w_k_valid_nxt;
      r_in_ready <= !w_k_valid_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_m_valid;
  assign out_imm     = r_m.imm;
  assign out_fmt     = r_m.fmt;
  assign out_illegal = r_m.illegal;
  assign out_tag     = r_m.tag;

endmodule
